iir_out_requant: RTL and testbench

//  Downstream stage of the Chebyshev high-pass IIR: consumes its 18-bit result each sample, optionally decimates,

---
 rtl/iir_pkg.sv | 11 +
 rtl/iir_sync_fifo.sv | 63 ++++++
 rtl/iir_out_requant.sv | 118 +++++++++++
 tb/tb_iir_out_requant.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iir_pkg.sv
// Constants shared by the IIR filter chain and its output requantizer.
package iir_pkg;
   localparam int unsigned IIR_DATA_W     = 18;
   localparam int unsigned IIR_IN_W       = 8;
   localparam int unsigned IIR_OUT_W      = 8;
   localparam int unsigned IIR_SHIFT      = 7;
   localparam int unsigned IIR_DECIM      = 1;
   localparam int unsigned IIR_FIFO_DEPTH = 4;
   localparam int unsigned IIR_SATCNT_W   = 16;
   localparam int unsigned IIR_DECCNT_W   = 8;
endpackage

// File: rtl/iir_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; head, occupancy, valid and full are all registered.
module iir_sync_fifo
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wr,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   rd,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   valid,
   output logic                   full,
   output logic [$clog2(DEPTH):0] level
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt_c;
   logic [LW-1:0]    level_nxt_c;
   logic [WIDTH-1:0] head_nxt_c;
   logic             do_wr_c;
   logic             do_rd_c;

   // Next head: bypass the write data when the new head slot is written this cycle; hold when empty.
   always_comb begin
      do_rd_c      = rd && valid;
      do_wr_c      = wr && (!full || do_rd_c);
      rd_ptr_nxt_c = do_rd_c ? rd_ptr + AW'(1) : rd_ptr;
      level_nxt_c  = level + LW'(do_wr_c) - LW'(do_rd_c);
      head_nxt_c   = rd_data;
      if (level_nxt_c != '0)
         head_nxt_c = (do_wr_c && (rd_ptr_nxt_c == wr_ptr)) ? wr_data : mem[rd_ptr_nxt_c];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         valid   <= 1'b0;
         full    <= 1'b0;
         rd_data <= '0;
      end else begin
         if (do_wr_c)
            wr_ptr <= wr_ptr + AW'(1);
         rd_ptr  <= rd_ptr_nxt_c;
         level   <= level_nxt_c;
         valid   <= (level_nxt_c != '0);
         full    <= (level_nxt_c == LW'(DEPTH));
         rd_data <= head_nxt_c;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr_c)
         mem[wr_ptr] <= wr_data;
   end
endmodule

// File: rtl/iir_out_requant.sv
// IIR output stage: decimate, round/shift, saturate, buffer in a FWFT FIFO with valid/ready hand-off.
// Define IIR_REQUANT_SATCNT_EN to add the sat_count saturation-event counter port.
module iir_out_requant
   import iir_pkg::*;
#(
   parameter int unsigned IN_W       = IIR_DATA_W,
   parameter int unsigned OUT_W      = IIR_OUT_W,
   parameter int unsigned SHIFT      = IIR_SHIFT,
   parameter int unsigned DECIM      = IIR_DECIM,
   parameter int unsigned FIFO_DEPTH = IIR_FIFO_DEPTH
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [IN_W-1:0]             in_data,
   input  logic                        in_valid,
   output logic [OUT_W-1:0]            out_data,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level,
   output logic                        overflow
`ifdef IIR_REQUANT_SATCNT_EN
   ,
   output logic [IIR_SATCNT_W-1:0]     sat_count
`endif
);
   localparam int unsigned EXT_W = IN_W + 1;
   localparam int unsigned CNT_W = IIR_DECCNT_W;
   localparam logic [CNT_W-1:0]        DEC_LAST = CNT_W'(DECIM - 1);
   localparam logic signed [EXT_W-1:0] RND      = EXT_W'(1 << (SHIFT - 1));
   localparam logic signed [EXT_W-1:0] SAT_HI   = EXT_W'((1 << (OUT_W - 1)) - 1);
   localparam logic signed [EXT_W-1:0] SAT_LO   = ~SAT_HI;

   logic [CNT_W-1:0]        dec_cnt;
   logic                    pass_c;
   logic signed [EXT_W-1:0] ext_c;
   logic signed [EXT_W-1:0] rnd_c;
   logic                    s1_valid;
   logic signed [EXT_W-1:0] s1_r;
   logic                    s2_valid;
   logic                    s2_sat;
   logic [OUT_W-1:0]        s2_data;
   logic                    pop_c;
   logic                    fifo_full;

   // Decimation gate and round-half-up arithmetic shift (one guard bit keeps the add exact).
   always_comb begin
      pass_c = in_valid && (dec_cnt == '0);
      ext_c  = {in_data[IN_W-1], in_data};
      rnd_c  = (ext_c + RND) >>> SHIFT;
      pop_c  = out_valid && out_ready;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         dec_cnt <= '0;
      else if (in_valid)
         dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid <= 1'b0;
         s1_r     <= '0;
         s2_valid <= 1'b0;
         s2_sat   <= 1'b0;
         s2_data  <= '0;
      end else begin
         s1_valid <= pass_c;
         if (pass_c)
            s1_r <= rnd_c;
         s2_valid <= s1_valid;
         if (s1_valid) begin
            if (s1_r > SAT_HI) begin
               s2_data <= {1'b0, {(OUT_W-1){1'b1}}};
               s2_sat  <= 1'b1;
            end else if (s1_r < SAT_LO) begin
               s2_data <= {1'b1, {(OUT_W-1){1'b0}}};
               s2_sat  <= 1'b1;
            end else begin
               s2_data <= s1_r[OUT_W-1:0];
               s2_sat  <= 1'b0;
            end
         end
      end
   end

   // A stage-2 sample meeting a full FIFO with no pop is lost; remember that until reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         overflow <= 1'b0;
      else if (s2_valid && fifo_full && !pop_c)
         overflow <= 1'b1;
   end

`ifdef IIR_REQUANT_SATCNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         sat_count <= '0;
      else if (s2_valid && s2_sat && (sat_count != '1))
         sat_count <= sat_count + IIR_SATCNT_W'(1);
   end
`endif

   iir_sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr      (s2_valid),
      .wr_data (s2_data),
      .rd      (pop_c),
      .rd_data (out_data),
      .valid   (out_valid),
      .full    (fifo_full),
      .level   (fifo_level)
   );
endmodule

// File: tb/tb_iir_out_requant.sv
// Bench for iir_out_requant: directed literal cases plus random traffic against a queue-based model.
module tb_iir_out_requant;
   logic        clk;
   logic        rst;
   logic [17:0] in_data;
   logic        in_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic [2:0]  fifo_level;
   logic        overflow;
   logic [7:0]  d_data;
   logic        d_valid;
   logic [2:0]  d_level;
   logic        d_overflow;
`ifdef IIR_REQUANT_SATCNT_EN
   logic [15:0] sat_count;
   logic [15:0] d_sat_count;
`endif

   int n_chk;
   int n_fail;

   typedef struct {
      logic [7:0] v;
      bit         sat;
      int         due;
   } item_t;

   item_t      pipe[$];
   logic [7:0] fq[$];
   logic [7:0] dq[$];
   logic [7:0] dec_got[$];
   logic [7:0] m_last;
   bit         m_ovf;
   int         m_sat;
   int         dcnt;
   int         cyc;
   bit         m_pop;
   item_t      it;

   iir_out_requant #(.IN_W(18), .OUT_W(8), .SHIFT(7), .DECIM(1), .FIFO_DEPTH(4)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .fifo_level (fifo_level),
      .overflow   (overflow)
`ifdef IIR_REQUANT_SATCNT_EN
      ,
      .sat_count  (sat_count)
`endif
   );

   iir_out_requant #(.IN_W(18), .OUT_W(8), .SHIFT(7), .DECIM(3), .FIFO_DEPTH(4)) u_dec (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_data   (d_data),
      .out_valid  (d_valid),
      .out_ready  (1'b1),
      .fifo_level (d_level),
      .overflow   (d_overflow)
`ifdef IIR_REQUANT_SATCNT_EN
      ,
      .sat_count  (d_sat_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Ideal requantization: floor((x + 64) / 128), clamped to the signed 8-bit range.
   function automatic int rq_int(input logic [17:0] x);
      return (int'($signed(x)) + 64) >>> 7;
   endfunction

   function automatic logic [7:0] rq(input logic [17:0] x);
      int v;
      v = rq_int(x);
      if (v > 127) return 8'h7F;
      if (v < -128) return 8'h80;
      return 8'(v);
   endfunction

   function automatic bit is_sat(input logic [17:0] x);
      int v;
      v = rq_int(x);
      return (v > 127) || (v < -128);
   endfunction

   // Reference: each accepted sample reaches the FIFO two edges after capture; FIFO holds 4.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe.delete();
         fq.delete();
         dq.delete();
         m_ovf  = 1'b0;
         m_last = 8'h00;
         m_sat  = 0;
         dcnt   = 0;
         cyc    = 0;
      end else begin
         m_pop = (fq.size() != 0) && out_ready;
         if (pipe.size() != 0 && pipe[0].due == cyc) begin
            it = pipe.pop_front();
            if (it.sat && m_sat < 65535) m_sat++;
            if (fq.size() == 4 && !m_pop) m_ovf = 1'b1;
            else fq.push_back(it.v);
         end
         if (m_pop) void'(fq.pop_front());
         if (in_valid) begin
            it.v   = rq(in_data);
            it.sat = is_sat(in_data);
            it.due = cyc + 2;
            pipe.push_back(it);
            if (dcnt == 0) dq.push_back(rq(in_data));
            dcnt = (dcnt + 1) % 3;
         end
         if (fq.size() != 0) m_last = fq[0];
         cyc++;
      end
   end

   always @(negedge clk) begin
      chk("out_valid", int'(out_valid), int'(fq.size() != 0));
      chk("fifo_level", int'(fifo_level), fq.size());
      chk("overflow", int'(overflow), int'(m_ovf));
      chk("out_data", int'(out_data), int'((fq.size() != 0) ? fq[0] : m_last));
`ifdef IIR_REQUANT_SATCNT_EN
      chk("sat_count", int'(sat_count), m_sat);
`endif
      if (rst && d_valid) begin
         if (dq.size() == 0) chk("dec_unexpected", 1, 0);
         else chk("dec_data", int'(d_data), int'(dq.pop_front()));
      end
   end

   always @(negedge clk or negedge rst) begin
      if (!rst) dec_got.delete();
      else if (d_valid) dec_got.push_back(d_data);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst = 1'b0;
      #2;
      rst = 1'b1;
      step();
   endtask

   task automatic send_one(input logic [17:0] x, input logic [7:0] exp);
      in_data  = x;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      chk("lat_early_valid", int'(out_valid), 0);
      step();
      chk("lat_valid", int'(out_valid), 1);
      chk("lat_data", int'(out_data), int'(exp));
   endtask

   initial begin
      n_chk = 0;
      n_fail = 0;
      rst = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      out_ready = 1'b0;
      repeat (2) step();
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_level", int'(fifo_level), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_data", int'(out_data), 0);
      rst = 1'b1;
      out_ready = 1'b1;
      step();

      // Rounding and saturation
      send_one(18'd640, 8'h05);
      send_one(18'd192, 8'h02);
      send_one(18'h3FF40, 8'hFF);
      send_one(18'd20000, 8'h7F);
      send_one(18'h3B1E0, 8'h80);
`ifdef IIR_REQUANT_SATCNT_EN
      chk("sat_count_two", int'(sat_count), 2);
`endif

      // Back-pressure with overflow
      do_reset();
      out_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         in_data = 18'(k * 128);
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      repeat (3) step();
      chk("bp_level", int'(fifo_level), 4);
      chk("bp_overflow", int'(overflow), 1);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk("bp_order", int'(out_data), k);
         step();
      end
      chk("bp_empty", int'(out_valid), 0);

      // Full FIFO with simultaneous pop and push
      do_reset();
      out_ready = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         in_data = 18'(k * 128);
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      chk("full_head1", int'(out_data), 1);
      step();
      chk("full_level_a", int'(fifo_level), 4);
      chk("full_head2", int'(out_data), 2);
      step();
      chk("full_level_b", int'(fifo_level), 4);
      chk("full_no_ovf", int'(overflow), 0);
      for (int k = 3; k <= 6; k++) begin
         chk("full_order", int'(out_data), k);
         step();
      end

      // Decimation by 3 on the second instance
      do_reset();
      for (int k = 0; k <= 8; k++) begin
         in_data = 18'(k * 128);
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      repeat (4) step();
      chk("dec_count", dec_got.size(), 3);
      if (dec_got.size() == 3) begin
         chk("dec_0", int'(dec_got[0]), 0);
         chk("dec_1", int'(dec_got[1]), 3);
         chk("dec_2", int'(dec_got[2]), 6);
      end

      // Reset with buffered and in-flight samples
      do_reset();
      out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         in_data = 18'(k * 128);
         in_valid = 1'b1;
         step();
      end
      in_valid = 1'b0;
      chk("pre_rst_level", int'(fifo_level), 3);
      rst = 1'b0;
      #1;
      chk("mid_rst_valid", int'(out_valid), 0);
      chk("mid_rst_level", int'(fifo_level), 0);
      chk("mid_rst_overflow", int'(overflow), 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      out_ready = 1'b1;
      send_one(18'(7 * 128), 8'h07);
      chk("post_rst_level", int'(fifo_level), 1);
      chk("post_rst_dec_valid", int'(d_valid), 1);
      chk("post_rst_dec_data", int'(d_data), 7);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            rst = 1'b0;
            #2;
            rst = 1'b1;
         end
         in_valid = ($urandom % 10) < 7;
         if ($urandom % 2 == 0) in_data = 18'($urandom_range(40000) - 20000);
         else in_data = 18'($urandom);
         case ((i / 500) % 3)
            0: out_ready = ($urandom % 10) < 9;
            1: out_ready = ($urandom % 10) < 3;
            default: out_ready = ($urandom % 2) == 0;
         endcase
         step();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (12) step();
      chk("drain_empty", int'(out_valid), 0);
      chk("drain_dec_empty", dq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
